// File: rtl/tour_pkg.sv
// Shared types and move tables for the Knight's Tour solver.
// Move bit i encodes offset (DX[i], DY[i]), +y = north.
package tour_pkg;

  typedef enum logic [2:0] {IDLE, INIT, POSSIBLE, MAKE_MOVE, BACKUP} state_t;

  localparam logic [7:0] MV_P1P2 = 8'h01;
  localparam logic [7:0] MV_M1P2 = 8'h02;
  localparam logic [7:0] MV_M2P1 = 8'h04;
  localparam logic [7:0] MV_M2M1 = 8'h08;
  localparam logic [7:0] MV_M1M2 = 8'h10;
  localparam logic [7:0] MV_P1M2 = 8'h20;
  localparam logic [7:0] MV_P2M1 = 8'h40;
  localparam logic [7:0] MV_P2P1 = 8'h80;

  localparam logic signed [3:0] DX [8] = '{4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd2, 4'sd2};
  localparam logic signed [3:0] DY [8] = '{4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1};

  function automatic logic [2:0] mv_idx(input logic [7:0] oh);
    mv_idx = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (oh[i]) mv_idx = 3'(i);
  endfunction

  // Coordinate step in 4-bit signed, truncated back to 3 bits.
  function automatic logic [2:0] step(input logic [2:0] c, input logic signed [3:0] d,
                                      input logic back);
    logic signed [3:0] s;
    s = back ? ($signed({1'b0, c}) - d) : ($signed({1'b0, c}) + d);
    return s[2:0];
  endfunction

endpackage

// File: rtl/tour_logic_if.sv
// Control/readback bundle between the tour solver and the command sequencer.
// Optional TOUR_FAIL_EN adds the `fail` pulse.
interface tour_logic_if;
  logic       go;
  logic [2:0] x_start;
  logic [2:0] y_start;
  logic [4:0] indx;
  logic [7:0] move;
  logic       done;
`ifdef TOUR_FAIL_EN
  logic       fail;
`endif

  modport master (
    output go, x_start, y_start, indx,
`ifdef TOUR_FAIL_EN
    input  fail,
`endif
    input  move, done
  );

  modport slave (
    input  go, x_start, y_start, indx,
`ifdef TOUR_FAIL_EN
    output fail,
`endif
    output move, done
  );
endinterface

// File: rtl/tour_poss_moves.sv
// Combinational mask of knight moves from (xx, yy) that land on the board.
module tour_poss_moves
  import tour_pkg::*;
#(
  parameter int BOARD_DIM = 5
) (
  input  logic [2:0] xx,
  input  logic [2:0] yy,
  output logic [7:0] poss
);
  localparam logic signed [3:0] DIM = 4'(BOARD_DIM);

  logic signed [3:0] tx, ty;

  always_comb begin
    poss = '0;
    tx   = '0;
    ty   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      tx      = $signed({1'b0, xx}) + DX[i];
      ty      = $signed({1'b0, yy}) + DY[i];
      poss[i] = (tx >= 4'sd0) && (tx < DIM) && (ty >= 4'sd0) && (ty < DIM);
    end
  end
endmodule

// File: rtl/tour_logic.sv
// Backtracking Knight's Tour search; moves read back by index after `done`.
// Optional TOUR_FAIL_EN adds a `fail` pulse when the search is exhausted.
module tour_logic
  import tour_pkg::*;
#(
  parameter int BOARD_DIM = 5
) (
  input logic         clk,
  input logic         rst_n,
  tour_logic_if.slave bus
);
  localparam int         TOUR_LEN = BOARD_DIM * BOARD_DIM - 1;
  localparam logic [4:0] LAST_NUM = 5'(TOUR_LEN - 1);

  state_t                                 state_q, state_d;
  logic [BOARD_DIM-1:0][BOARD_DIM-1:0]    visited_q, visited_d;
  logic [7:0]                             last_move_q [TOUR_LEN];
  logic [7:0]                             poss_q      [TOUR_LEN];
  logic [7:0]                             poss_d;
  logic [7:0]                             move_try_q, move_try_d;
  logic [2:0]                             xx_q, xx_d, yy_q, yy_d;
  logic [4:0]                             move_num_q, move_num_d;
  logic                                   done_q, done_d;
  logic                                   lm_we, poss_we;
  logic [2:0]                             tx, ty, bx, by, try_idx, undo_idx;
  logic [7:0]                             undone;
  logic                                   legal;
`ifdef TOUR_FAIL_EN
  logic                                   fail_q, fail_d;
  assign bus.fail = fail_q;
`endif

  tour_poss_moves #(.BOARD_DIM(BOARD_DIM)) u_poss (
    .xx   (xx_q),
    .yy   (yy_q),
    .poss (poss_d)
  );

  assign bus.done = done_q;
  assign bus.move = (bus.indx < 5'(TOUR_LEN)) ? last_move_q[bus.indx] : '0;

  always_comb begin
    try_idx  = mv_idx(move_try_q);
    tx       = step(xx_q, DX[try_idx], 1'b0);
    ty       = step(yy_q, DY[try_idx], 1'b0);
    legal    = |(poss_q[move_num_q] & move_try_q) && !visited_q[tx][ty];
    undone   = (move_num_q != '0) ? last_move_q[move_num_q - 5'd1] : '0;
    undo_idx = mv_idx(undone);
    bx       = step(xx_q, DX[undo_idx], 1'b1);
    by       = step(yy_q, DY[undo_idx], 1'b1);
  end

  always_comb begin
    state_d    = state_q;
    visited_d  = visited_q;
    move_try_d = move_try_q;
    xx_d       = xx_q;
    yy_d       = yy_q;
    move_num_d = move_num_q;
    done_d     = 1'b0;
    lm_we      = 1'b0;
    poss_we    = 1'b0;
`ifdef TOUR_FAIL_EN
    fail_d     = 1'b0;
`endif
    unique case (state_q)
      // The cycle that shows done/fail is still the tail of the search, so go is ignored there.
      IDLE: begin
`ifdef TOUR_FAIL_EN
        if (bus.go && !done_q && !fail_q) state_d = INIT;
`else
        if (bus.go && !done_q) state_d = INIT;
`endif
      end
      INIT: begin
        visited_d                           = '0;
        visited_d[bus.x_start][bus.y_start] = 1'b1;
        xx_d       = bus.x_start;
        yy_d       = bus.y_start;
        move_num_d = '0;
        state_d    = POSSIBLE;
      end
      POSSIBLE: begin
        poss_we    = 1'b1;
        move_try_d = MV_P1P2;
        state_d    = MAKE_MOVE;
      end
      MAKE_MOVE: begin
        if (legal) begin
          visited_d[tx][ty] = 1'b1;
          xx_d  = tx;
          yy_d  = ty;
          lm_we = 1'b1;
          if (move_num_q == LAST_NUM) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            move_num_d = move_num_q + 5'd1;
            state_d    = POSSIBLE;
          end
        end else if (move_try_q != MV_P2P1) begin
          move_try_d = move_try_q << 1;
        end else begin
          state_d = BACKUP;
        end
      end
      BACKUP: begin
        if (move_num_q == '0) begin
          state_d = IDLE;
`ifdef TOUR_FAIL_EN
          fail_d  = 1'b1;
`endif
        end else begin
          visited_d[xx_q][yy_q] = 1'b0;
          xx_d       = bx;
          yy_d       = by;
          move_num_d = move_num_q - 5'd1;
          if (undone != MV_P2P1) begin
            move_try_d = undone << 1;
            state_d    = MAKE_MOVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      visited_q  <= '0;
      move_try_q <= '0;
      xx_q       <= '0;
      yy_q       <= '0;
      move_num_q <= '0;
      done_q     <= 1'b0;
`ifdef TOUR_FAIL_EN
      fail_q     <= 1'b0;
`endif
      for (int unsigned i = 0; i < TOUR_LEN; i++) begin
        last_move_q[i] <= '0;
        poss_q[i]      <= '0;
      end
    end else begin
      state_q    <= state_d;
      visited_q  <= visited_d;
      move_try_q <= move_try_d;
      xx_q       <= xx_d;
      yy_q       <= yy_d;
      move_num_q <= move_num_d;
      done_q     <= done_d;
`ifdef TOUR_FAIL_EN
      fail_q     <= fail_d;
`endif
      if (lm_we)   last_move_q[move_num_q] <= move_try_q;
      if (poss_we) poss_q[move_num_q]      <= poss_d;
    end
  end
endmodule

// File: tb/tb_tour_logic.sv
// Directed bench for tour_logic: 5x5 tours replayed for legality, plus a 3x3 exhaustion run.
module tb_tour_logic;
  import tour_pkg::*;

  localparam int TIMEOUT = 2000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   bdx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int   bdy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  logic [7:0] snap [24];

  tour_logic_if bus5();
  tour_logic_if bus3();

  tour_logic #(.BOARD_DIM(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  tour_logic #(.BOARD_DIM(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  task automatic go5(input int sx, input int sy);
    @(negedge clk);
    bus5.x_start = 3'(sx);
    bus5.y_start = 3'(sy);
    bus5.go      = 1'b1;
    @(negedge clk);
    bus5.go      = 1'b0;
  endtask

  // Waits at negedges for done; returns the number of cycles waited, or -1 on timeout.
  task automatic wait_done5(output int cyc);
    cyc = -1;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (bus5.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic check_tour(input int sx, input int sy, input string tag);
    bit   seen [5][5];
    int   x, y, nx, ny, idx, cnt;
    logic [7:0] m;
    bit   ok;
    foreach (seen[i, j]) seen[i][j] = 1'b0;
    x = sx; y = sy; seen[x][y] = 1'b1; cnt = 1;
    for (int k = 0; k < 24; k++) begin
      bus5.indx = 5'(k);
      #1;
      m   = bus5.move;
      ok  = ($countones(m) == 1);
      idx = 0;
      for (int b = 0; b < 8; b++) if (m[b]) idx = b;
      nx = x + bdx[idx];
      ny = y + bdy[idx];
      if (ok) ok = (nx >= 0) && (nx < 5) && (ny >= 0) && (ny < 5);
      if (ok) ok = !seen[nx][ny];
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++;
        $display("FAIL %s step %0d: move=%h from (%0d,%0d), required one-hot to unvisited on-board square",
                 tag, k, m, x, y);
        break;
      end
      seen[nx][ny] = 1'b1; x = nx; y = ny; cnt++;
    end
    n_checks++;
    if (cnt !== 25) begin
      n_fail++;
      $display("FAIL %s coverage: visited %0d squares, required 25", tag, cnt);
    end
    bus5.indx = '0;
  endtask

  task automatic check_done_then_low(input int cyc, input string tag);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL %s done: timeout after %0d cycles, required a done pulse", tag, TIMEOUT);
    end
    @(negedge clk);
    n_checks++;
    if (bus5.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse width: done=%b one cycle later, required 0", tag, bus5.done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    foreach (snap[k]) begin
      bus5.indx = 5'(k);
      #1;
      n_checks++;
      if (bus5.move !== 8'h00) begin
        n_fail++;
        $display("FAIL reset move[%0d]: got %h, required 00", k, bus5.move);
      end
    end
    bus5.indx = '0;
    n_checks++;
    if (bus5.done !== 1'b0 || bus3.done !== 1'b0 || bus3.move !== 8'h00) begin
      n_fail++;
      $display("FAIL reset outputs: done5=%b done3=%b move3=%h, required 0/0/00",
               bus5.done, bus3.done, bus3.move);
    end
`ifdef TOUR_FAIL_EN
    n_checks++;
    if (bus5.fail !== 1'b0 || bus3.fail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset fail: fail5=%b fail3=%b, required 0", bus5.fail, bus3.fail);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tour_center;
    int cyc;
    go5(2, 2);
    wait_done5(cyc);
    check_done_then_low(cyc, "center");
    check_tour(2, 2, "center");
  endtask

  task automatic test_tour_corner;
    int cyc;
    go5(0, 0);
    wait_done5(cyc);
    check_done_then_low(cyc, "corner");
    bus5.indx = 5'd0;
    #1;
    n_checks++;
    if (bus5.move !== 8'h01 && bus5.move !== 8'h80) begin
      n_fail++;
      $display("FAIL corner first move: got %h, required 01 or 80", bus5.move);
    end
    check_tour(0, 0, "corner");
  endtask

  task automatic test_go_ignored;
    int cyc, extra;
    bit same;
    go5(0, 0);
    repeat (9) @(negedge clk);
    bus5.x_start = 3'd2;
    bus5.y_start = 3'd2;
    bus5.go      = 1'b1;
    @(negedge clk);
    bus5.go      = 1'b0;
    wait_done5(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL busy-go done: timeout after %0d cycles, required a done pulse", TIMEOUT);
    end
    bus5.go = 1'b1;  // coincident with done
    @(negedge clk);
    bus5.go = 1'b0;
    n_checks++;
    if (bus5.done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy-go pulse width: done=%b, required 0", bus5.done);
    end
    foreach (snap[k]) begin
      bus5.indx = 5'(k);
      #1;
      snap[k] = bus5.move;
    end
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus5.done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy-go extra done: got %0d pulses in idle window, required 0", extra);
    end
    same = 1'b1;
    foreach (snap[k]) begin
      bus5.indx = 5'(k);
      #1;
      if (bus5.move !== snap[k]) same = 1'b0;
    end
    n_checks++;
    if (same !== 1'b1) begin
      n_fail++;
      $display("FAIL busy-go stability: moves changed over 100 idle cycles, required unchanged");
    end
    check_tour(0, 0, "busy-go");
  endtask

  task automatic test_reset_mid_search;
    int cyc;
    go5(2, 2);
    repeat (500) @(negedge clk);
    rst_n     = 1'b0;
    bus5.indx = 5'd0;
    #1;
    n_checks++;
    if (bus5.move !== 8'h00 || bus5.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid-reset: move[0]=%h done=%b, required 00/0", bus5.move, bus5.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus5.move !== 8'h00 || bus5.done !== 1'b0) begin
      n_fail++;
      $display("FAIL post-reset: move[0]=%h done=%b, required 00/0", bus5.move, bus5.done);
    end
    go5(4, 4);
    wait_done5(cyc);
    check_done_then_low(cyc, "after-reset");
    check_tour(4, 4, "after-reset");
  endtask

  task automatic test_exhaust_3x3;
    int dones, fails;
    dones = 0;
    fails = 0;
    @(negedge clk);
    bus3.x_start = 3'd0;
    bus3.y_start = 3'd0;
    bus3.go      = 1'b1;
    @(negedge clk);
    bus3.go      = 1'b0;
    repeat (20000) begin
      @(negedge clk);
      if (bus3.done === 1'b1) dones++;
`ifdef TOUR_FAIL_EN
      if (bus3.fail === 1'b1) fails++;
`endif
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL 3x3 done: got %0d pulses, required 0", dones);
    end
`ifdef TOUR_FAIL_EN
    n_checks++;
    if (fails !== 1) begin
      n_fail++;
      $display("FAIL 3x3 fail: got %0d pulses, required 1", fails);
    end
`endif
  endtask

  initial begin
    bus5.go = 1'b0; bus5.x_start = '0; bus5.y_start = '0; bus5.indx = '0;
    bus3.go = 1'b0; bus3.x_start = '0; bus3.y_start = '0; bus3.indx = '0;
    test_reset();
    test_tour_center();
    test_tour_corner();
    test_go_ignored();
    test_reset_mid_search();
    test_exhaust_3x3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
